mc_control: RTL

- Multi-cycle MIPS main control unit: a Moore FSM sequencing fetch, decode, execute, memory and writeback over several clocks per instruction.
- Drop-in control source for the multi-cycle datapath.
- Same opcode set and ALUOp encoding as the single-cycle control decoder: R-type, lw, sw, beq, j.
- Sits between the instruction register's opcode field and the datapath muxes, write enables and the ALU-control block.

---
 rtl/mips_pkg.sv | 123 ++++++++++++
 rtl/mc_control.sv | 98 +++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control constants: opcodes, ALUOp codes, mux select codes,
// multi-cycle FSM state encoding and the per-state control word.
// Optional macro MC_CONTROL_ADDI_EN adds the addi execute/writeback states.
package mips_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // ALUOp codes presented to the ALU-control block
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;

  // ALU B input select
  localparam logic [1:0] ASRCB_REG   = 2'b00;
  localparam logic [1:0] ASRCB_FOUR  = 2'b01;
  localparam logic [1:0] ASRCB_IMM   = 2'b10;
  localparam logic [1:0] ASRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9
`ifdef MC_CONTROL_ADDI_EN
    , S_ADDIEX = 4'd10,
    S_ADDIWB  = 4'd11
`endif
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Control word asserted while the FSM sits in state s
  function automatic ctrl_t ctrl_for_state(state_t s);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALUOP_ADD;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = ASRCB_FOUR;
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: c.alu_src_b = ASRCB_IMMSH;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASRCB_IMM;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASRCB_REG;
      end
      S_RTYPEWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = ASRCB_REG;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ASRCB_IMM;
      end
      S_ADDIWB: c.reg_write = 1'b1;
`endif
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch, decode,
// execute, memory and writeback. Outputs are registered alongside the
// state so they depend only on the state register, never on Opcode.
// Optional macro MC_CONTROL_ADDI_EN enables addi (ADDIEX/ADDIWB states).
module mc_control
  import mips_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic [STATE_W-1:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  function automatic state_t next_state(state_t s, logic [5:0] op);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEMADR;
          OP_RTYPE:     n = S_EXEC;
          OP_BEQ:       n = S_BEQ;
          OP_J:         n = S_JUMP;
`ifdef MC_CONTROL_ADDI_EN
          OP_ADDI:      n = S_ADDIEX;
`endif
          default:      n = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // IR is stable here, so the opcode can be re-read safely
        if (op == OP_LW)      n = S_MEMRD;
        else if (op == OP_SW) n = S_MEMWR;
        else                  n = S_FETCH;
      end
      S_MEMRD:   n = S_MEMWB;
      S_EXEC:    n = S_RTYPEWB;
`ifdef MC_CONTROL_ADDI_EN
      S_ADDIEX:  n = S_ADDIWB;
`endif
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // Next-state selection from current state and IR opcode
  always_comb begin
    state_nxt = next_state(state, Opcode);
  end

  // State register with the matching control word registered beside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= ctrl_for_state(S_FETCH);
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_for_state(state_nxt);
    end
  end

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign PCSource    = ctrl.pc_source;
  assign state_dbg   = STATE_W'(state);

endmodule
